// File: rtl/pipe_sel_stage.sv
// N-input, W-bit operand selector feeding a registered stage with a 2-entry skid buffer.
// Valid/ready on both sides, synchronous flush, err flag for out-of-range selects.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no entry held; out_data keeps the last presented value
// ONE   | main holds the head entry; skid free, in_ready=1
// FULL  | main holds the head, skid holds the next entry; in_ready=0
module pipe_sel_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Encoding is {main_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic               main_err_q, main_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_err_q, skid_err_d;

    logic [WIDTH-1:0]   cap_data;
    logic               cap_err;
    logic               main_valid;
    logic               skid_valid;
    logic               accept;
    logic               drain;

    assign main_valid = state_q[1];
    assign skid_valid = state_q[0];

    // Registered state only: no path from out_ready to in_ready.
    assign in_ready  = rst_n && !skid_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

    // Out-of-range selects fall through with zero data and the error flag set.
    always_comb begin
        cap_data = '0;
        cap_err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                cap_data = in_data[i*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        if (flush) begin
            // Data registers are left alone; only the valids are squashed.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_data_d = cap_data;
                        main_err_d  = cap_err;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_d     = FULL;
                        skid_data_d = cap_data;
                        skid_err_d  = cap_err;
                    end else if (accept && drain) begin
                        main_data_d = cap_data;
                        main_err_d  = cap_err;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_err_d  = skid_err_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule
